// File: rtl/config_loader.sv
// Streaming bitstream loader: validates a header word, shifts the payload into
// the flat configuration bus, checks the trailing checksum and releases core reset.
module config_loader #(
  parameter int                    CONFIG_WIDTH = 42368,
  parameter int                    WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0] MAGIC        = 32'h6B465047
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    core_nreset,
  output logic                    busy,
  output logic                    error
);

  localparam int NWORDS  = CONFIG_WIDTH / WORD_WIDTH;
  localparam int CNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      count;
  logic [WORD_WIDTH-1:0] sum;
  logic                  xfer;

  assign busy         = (state == HEADER) || (state == LOAD) || (state == CHECK);
  assign word_ready   = busy && !start;
  assign xfer         = word_valid && word_ready;
  assign config_valid = (state == DONE);
  assign error        = (state == ERROR);

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = HEADER;
    end else if (xfer) begin
      unique case (state)
        HEADER:  state_next = (word_in == MAGIC) ? LOAD : ERROR;
        LOAD:    state_next = (count == LAST_IDX) ? CHECK : LOAD;
        CHECK:   state_next = (word_in == sum) ? DONE : ERROR;
        default: state_next = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      core_nreset <= 1'b0;
    end else begin
      state       <= state_next;
      // Registered view of "next state is DONE": high exactly while in DONE.
      core_nreset <= (state_next == DONE);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
      sum   <= '0;
    end else if (start) begin
      count <= '0;
      sum   <= '0;
    end else if (xfer) begin
      if (state == HEADER) begin
        count <= '0;
        sum   <= '0;
      end else if (state == LOAD) begin
        sum <= sum + word_in;
        if (count != LAST_IDX) count <= count + 1'b1;
      end
    end
  end

  // NOTE: the wide shift register is reset asynchronously on purpose, so the
  // core never sees undefined configuration bits after power-up.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      config_out <= '0;
    end else if (xfer && (state == LOAD)) begin
      config_out <= {word_in, config_out[CONFIG_WIDTH-1:WORD_WIDTH]};
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader: a word-level model predicts every output
// each cycle; literal checks pin the model on the documented scenarios.
module tb_config_loader;

  localparam int          CW     = 42368;
  localparam int          WW     = 32;
  localparam int          NWORDS = CW / WW;
  localparam logic [31:0] MAGIC  = 32'h6B465047;

  localparam int P_IDLE = 0, P_HDR = 1, P_PAY = 2, P_TRL = 3, P_DONE = 4, P_ERR = 5;

  logic          clock = 1'b0;
  logic          nreset;
  logic          start;
  logic [WW-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] config_out;
  logic          config_valid;
  logic          core_nreset;
  logic          busy;
  logic          error;

  int checks = 0;
  int errors = 0;

  // Model state: what phase of the bitstream we are in, and what has been received.
  int          m_phase;
  int          m_cnt;
  logic [31:0] m_sum;
  logic [31:0] m_words [NWORDS];

  config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW), .MAGIC(MAGIC)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .start       (start),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .config_out  (config_out),
    .config_valid(config_valid),
    .core_nreset (core_nreset),
    .busy        (busy),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_sum   = '0;
    end else if (start) begin
      m_phase = P_HDR;
      m_cnt   = 0;
      m_sum   = '0;
    end else if (word_valid && m_phase >= P_HDR && m_phase <= P_TRL) begin
      if (m_phase == P_HDR) begin
        m_phase = (word_in == MAGIC) ? P_PAY : P_ERR;
      end else if (m_phase == P_PAY) begin
        m_words[m_cnt] = word_in;
        m_sum          = m_sum + word_in;
        m_cnt++;
        if (m_cnt == NWORDS) m_phase = P_TRL;
      end else begin
        m_phase = (word_in == m_sum) ? P_DONE : P_ERR;
      end
    end
  end

  // Compare process: all control outputs every cycle; full config bus while valid.
  always @(negedge clock) begin
    bit in_load;
    in_load = (m_phase >= P_HDR) && (m_phase <= P_TRL);
    check("word_ready",   {31'b0, word_ready},   {31'b0, in_load && !start});
    check("busy",         {31'b0, busy},         {31'b0, in_load});
    check("error",        {31'b0, error},        {31'b0, m_phase == P_ERR});
    check("config_valid", {31'b0, config_valid}, {31'b0, m_phase == P_DONE});
    check("core_nreset",  {31'b0, core_nreset},  {31'b0, m_phase == P_DONE});
    if (!nreset) check("config_out_reset", {31'b0, config_out != '0}, 32'd0);
    if (m_phase == P_DONE) begin
      int bad, first;
      bad = 0; first = -1;
      for (int i = 0; i < NWORDS; i++)
        if (config_out[WW*i +: WW] !== m_words[i]) begin
          bad++;
          if (first < 0) first = i;
        end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL config_out: %0d words differ, first at %0d got %h expected %h",
                 bad, first, config_out[WW*first +: WW], m_words[first]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input bit with_valid);
    start      = 1'b1;
    word_valid = with_valid;
    word_in    = MAGIC;
    tick();
    start      = 1'b0;
    word_valid = 1'b0;
  endtask

  // Present one word (after an optional random idle gap) and hold it until accepted.
  task automatic send_word(input logic [31:0] w, input int gap_pct);
    bit rdy;
    int budget;
    while ($urandom_range(99) < gap_pct) begin
      word_valid = 1'b0;
      word_in    = $urandom;
      tick();
    end
    word_valid = 1'b1;
    word_in    = w;
    budget     = 0;
    forever begin
      @(negedge clock);
      rdy = word_ready;
      tick();
      if (rdy) break;
      if (++budget > 1000) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got ready=0 expected ready=1 within 1000 cycles");
        break;
      end
    end
    word_valid = 1'b0;
  endtask

  // Full load: header, payload (i or random), trailer (correct or sum+1).
  task automatic run_load(input bit rand_pay, input bit bad_sum, input int gap_pct);
    logic [31:0] s, w;
    s = '0;
    send_word(MAGIC, gap_pct);
    for (int i = 0; i < NWORDS; i++) begin
      w = rand_pay ? 32'($urandom) : 32'(i);
      s = s + w;
      send_word(w, gap_pct);
    end
    send_word(bad_sum ? s + 32'd1 : s, gap_pct);
  endtask

  initial begin
    nreset     = 1'b0;
    start      = 1'b0;
    word_valid = 1'b1;
    word_in    = MAGIC;
    repeat (4) tick();
    check("reset_ready", {31'b0, word_ready}, 32'd0);
    check("reset_cfg_lo", config_out[31:0], 32'd0);
    word_valid = 1'b0;
    #2 nreset  = 1'b1;
    repeat (2) tick();

    // Clean load with payload i = index.
    pulse_start(1'b0);
    run_load(1'b0, 1'b0, 0);
    check("clean_valid", {31'b0, config_valid}, 32'd1);
    check("clean_core_nreset", {31'b0, core_nreset}, 32'd1);
    check("clean_busy", {31'b0, busy}, 32'd0);
    check("clean_error", {31'b0, error}, 32'd0);
    check("clean_cfg_lo", config_out[31:0], 32'd0);
    check("clean_cfg_hi", config_out[CW-1 -: 32], 32'd1323);
    check("model_sum", m_sum, 32'h000D5D32);
    repeat (3) tick();

    // Bad header, then a clean recovery load.
    pulse_start(1'b0);
    send_word(32'h0000_0000, 0);
    check("badhdr_error", {31'b0, error}, 32'd1);
    check("badhdr_core_nreset", {31'b0, core_nreset}, 32'd0);
    check("badhdr_ready", {31'b0, word_ready}, 32'd0);
    repeat (2) tick();
    pulse_start(1'b0);
    run_load(1'b0, 1'b0, 0);
    check("recover_valid", {31'b0, config_valid}, 32'd1);

    // Bad checksum (trailer 0x000D5D33).
    pulse_start(1'b0);
    run_load(1'b0, 1'b1, 0);
    check("badsum_error", {31'b0, error}, 32'd1);
    check("badsum_valid", {31'b0, config_valid}, 32'd0);

    // Restart after 500 payload words, then a full random load.
    pulse_start(1'b0);
    send_word(MAGIC, 0);
    for (int i = 0; i < 500; i++) send_word($urandom, 0);
    pulse_start(1'b0);
    run_load(1'b1, 1'b0, 0);
    check("restart_valid", {31'b0, config_valid}, 32'd1);

    // Backpressure/gaps, with start colliding with word_valid.
    pulse_start(1'b1);
    run_load(1'b0, 1'b0, 40);
    check("gaps_valid", {31'b0, config_valid}, 32'd1);
    check("gaps_cfg_lo", config_out[31:0], 32'd0);
    check("gaps_cfg_hi", config_out[CW-1 -: 32], 32'd1323);

    // Random payload with gaps; restart from DONE with word_valid high.
    pulse_start(1'b1);
    run_load(1'b1, 1'b0, 25);
    check("rand_valid", {31'b0, config_valid}, 32'd1);

    // nreset mid-load.
    pulse_start(1'b0);
    send_word(MAGIC, 0);
    for (int i = 0; i < 20; i++) send_word($urandom, 0);
    #2 nreset = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_cfg_lo", config_out[31:0], 32'd0);
    tick();
    nreset = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
